// File: rtl/mem_responder_pkg.sv
// Shared definitions for the tagged memory command bus.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_CMD_NONE  = 2'd0,
    MEM_CMD_LOAD  = 2'd1,
    MEM_CMD_STORE = 2'd2
  } mem_cmd_t;

  typedef logic [3:0]  mem_tag_t;
  typedef logic [63:0] mem_blk_t;

  // Tags 1..15 are grantable; 0 on r_response means refused.
  localparam int       MEM_TAGS      = 15;
  localparam mem_tag_t MEM_TAG_FIRST = 4'd1;

  // Next tag in the 1..15 ring; 0 is never produced.
  function automatic mem_tag_t mem_tag_advance(input mem_tag_t tag);
    return (tag == mem_tag_t'(MEM_TAGS)) ? MEM_TAG_FIRST : tag + 4'd1;
  endfunction

endpackage

// File: rtl/mem_inflight_q.sv
// In-flight request FIFO: 15 entries of {tag, data, countdown}.
// Every entry counts down once per cycle. The head becomes due when its
// countdown reaches 1, which is the cycle before its completion beat.
module mem_inflight_q
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [3:0]  push_tag,
  input  logic [63:0] push_data,
  input  logic        pop,
  output logic        head_due,
  output logic [3:0]  head_tag,
  output logic [63:0] head_data,
  output logic [3:0]  count
);

  mem_tag_t         tag_q  [MEM_TAGS];
  mem_blk_t         data_q [MEM_TAGS];
  logic [CNT_W-1:0] cnt_q  [MEM_TAGS];
  logic [3:0]       head;
  logic [3:0]       tail;
  logic [3:0]       count_q;

  function automatic logic [3:0] ptr_inc(input logic [3:0] ptr);
    return (ptr == 4'(MEM_TAGS - 1)) ? 4'd0 : ptr + 4'd1;
  endfunction

  // Entry payload is only written on push, so it needs no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      tag_q[tail]  <= push_tag;
      data_q[tail] <= push_data;
    end
  end

  // Countdowns: a fresh entry starts at LATENCY-1, all others tick toward 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MEM_TAGS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < MEM_TAGS; i++) begin
        if (push && (tail == 4'(i))) begin
          cnt_q[i] <= CNT_W'(LATENCY - 1);
        end else if (cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  // Circular pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      head    <= 4'd0;
      tail    <= 4'd0;
      count_q <= 4'd0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_due  = (count_q != 4'd0) && (cnt_q[head] == CNT_W'(1));
  assign head_tag  = tag_q[head];
  assign head_data = data_q[head];
  assign count     = count_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: grants a tag combinationally on accept, snapshots
// load data at the accept edge, and returns a completion beat LATENCY
// cycles later. Acts as the reference memory of the system.
//
// An entry leaves the FIFO when it moves into the output registers, so
// "outstanding" is the FIFO occupancy plus the beat currently on r_tag.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8192
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  t_command,
  input  logic [31:0] t_addr,
  input  logic [63:0] t_data,
  input  logic        busy,
  output logic [3:0]  r_response,
  output logic [63:0] r_data,
  output logic [3:0]  r_tag
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  mem_blk_t   mem [DEPTH];
  mem_tag_t   next_tag;
  logic [31:0] word_idx;
  logic [AW-1:0] idx;
  logic       in_range;
  logic [2:0] unused_byte_sel;
  logic       is_load;
  logic       is_store;
  logic       accept;
  logic [4:0] outstanding;
  mem_blk_t   entry_data;

  logic       q_push;
  logic       q_pop;
  logic       q_head_due;
  logic [3:0] q_head_tag;
  logic [63:0] q_head_data;
  logic [3:0] q_count;

  // Word addressing: the byte offset is ignored, and anything at or above
  // DEPTH (including non-zero high address bits) is out of range.
  assign word_idx        = {3'b000, t_addr[31:3]};
  assign idx             = word_idx[AW-1:0];
  assign in_range        = (word_idx < 32'(DEPTH));
  assign unused_byte_sel = t_addr[2:0];

  // Accept decision, tag grant and load snapshot for the current request.
  always_comb begin
    is_load     = (t_command == MEM_CMD_LOAD);
    is_store    = (t_command == MEM_CMD_STORE);
    outstanding = {1'b0, q_count} + {4'b0000, (r_tag != 4'd0)};
    accept      = (is_load || is_store) && !busy && !reset &&
                  (outstanding < 5'(MEM_TAGS));
    r_response  = accept ? next_tag : 4'd0;
    entry_data  = '0;
    if (is_load && in_range) entry_data = mem[idx];
  end

  // Tag ring advances only on accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      next_tag <= MEM_TAG_FIRST;
    end else if (accept) begin
      next_tag <= mem_tag_advance(next_tag);
    end
  end

  // Backing store survives reset; out-of-range stores are dropped.
  always_ff @(posedge clock) begin
    if (accept && is_store && in_range) begin
      mem[idx] <= t_data;
    end
  end

  // With LATENCY of 1 the beat is loaded straight from the accept; otherwise
  // the FIFO supplies it one cycle ahead.
  assign q_push = accept && (LATENCY > 1);
  assign q_pop  = q_head_due && (LATENCY > 1);

  mem_inflight_q #(
    .LATENCY (LATENCY),
    .CNT_W   (CNT_W)
  ) u_inflight_q (
    .clock     (clock),
    .reset     (reset),
    .push      (q_push),
    .push_tag  (next_tag),
    .push_data (entry_data),
    .pop       (q_pop),
    .head_due  (q_head_due),
    .head_tag  (q_head_tag),
    .head_data (q_head_data),
    .count     (q_count)
  );

  // Completion beat registers; data is forced to 0 whenever no beat is shown.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tag  <= 4'd0;
      r_data <= '0;
    end else if (LATENCY == 1) begin
      r_tag  <= accept ? next_tag : 4'd0;
      r_data <= accept ? entry_data : '0;
    end else if (q_head_due) begin
      r_tag  <= q_head_tag;
      r_data <= q_head_data;
    end else begin
      r_tag  <= 4'd0;
      r_data <= '0;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY=4 for the
// data-path cases, one at LATENCY=20 for the full/wrap case.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  c4 = 2'd0, c20 = 2'd0;
  logic [31:0] a4 = '0, a20 = '0;
  logic [63:0] d4 = '0, d20 = '0;
  logic        b4 = 1'b0, b20 = 1'b0;
  logic [3:0]  resp4, resp20, rtag4, rtag20;
  logic [63:0] rdata4, rdata20;
  int          tests = 0;
  int          failed = 0;

  always #5 clock = ~clock;

  mem_responder #(.LATENCY(4), .DEPTH(8192)) dut (
    .clock(clock), .reset(reset), .t_command(c4), .t_addr(a4), .t_data(d4),
    .busy(b4), .r_response(resp4), .r_data(rdata4), .r_tag(rtag4)
  );

  mem_responder #(.LATENCY(20), .DEPTH(8192)) dut20 (
    .clock(clock), .reset(reset), .t_command(c20), .t_addr(a20), .t_data(d20),
    .busy(b20), .r_response(resp20), .r_data(rdata20), .r_tag(rtag20)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drv4(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
    c4 = c; a4 = a; d4 = d;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    drv4(MEM_CMD_LOAD, 32'h1000, 64'h0); #1;
    chk("reset_resp", 64'(resp4), 64'h0);
    chk("reset_tag", 64'(rtag4), 64'h0);
    chk("reset_data", rdata4, 64'h0);
    drv4(MEM_CMD_NONE, 32'h0, 64'h0);

    // cycle 0
    @(negedge clock); reset = 1'b0;
    drv4(MEM_CMD_STORE, 32'h1000, 64'hDEADBEEF_CAFEF00D); #1;
    chk("store_grant", 64'(resp4), 64'd1);
    // cycle 1
    @(negedge clock);
    chk("c1_idle", 64'(rtag4), 64'd0);
    drv4(MEM_CMD_LOAD, 32'h1000, 64'h0); #1;
    chk("load_grant", 64'(resp4), 64'd2);
    // cycle 2, 3
    @(negedge clock); drv4(MEM_CMD_NONE, 32'h0, 64'h0);
    chk("c2_idle", 64'(rtag4), 64'd0);
    @(negedge clock);
    chk("c3_not_early", 64'(rtag4), 64'd0);
    // cycle 4, 5
    @(negedge clock);
    chk("c4_store_tag", 64'(rtag4), 64'd1);
    chk("c4_store_data", rdata4, 64'h0);
    @(negedge clock);
    chk("c5_load_tag", 64'(rtag4), 64'd2);
    chk("c5_load_data", rdata4, 64'hDEADBEEF_CAFEF00D);
    // cycle 6..9: low address bits ignored, load snapshot
    @(negedge clock);
    chk("c6_idle_tag", 64'(rtag4), 64'd0);
    chk("c6_idle_data", rdata4, 64'h0);
    drv4(MEM_CMD_STORE, 32'h1004, 64'h1234); #1;
    chk("c6_grant", 64'(resp4), 64'd3);
    @(negedge clock); drv4(MEM_CMD_LOAD, 32'h1000, 64'h0); #1;
    chk("c7_grant", 64'(resp4), 64'd4);
    @(negedge clock); drv4(MEM_CMD_STORE, 32'h1000, 64'h5555); #1;
    chk("c8_grant", 64'(resp4), 64'd5);
    @(negedge clock); drv4(MEM_CMD_LOAD, 32'h1000, 64'h0); #1;
    chk("c9_grant", 64'(resp4), 64'd6);
    @(negedge clock); drv4(MEM_CMD_NONE, 32'h0, 64'h0);
    chk("c10_tag", 64'(rtag4), 64'd3);
    chk("c10_data", rdata4, 64'h0);
    @(negedge clock);
    chk("c11_tag", 64'(rtag4), 64'd4);
    chk("c11_snapshot", rdata4, 64'h1234);
    @(negedge clock);
    chk("c12_tag", 64'(rtag4), 64'd5);
    @(negedge clock);
    chk("c13_tag", 64'(rtag4), 64'd6);
    chk("c13_data", rdata4, 64'h5555);
    // cycle 14: busy; cycle 15: reserved command
    @(negedge clock); b4 = 1'b1; drv4(MEM_CMD_LOAD, 32'h1000, 64'h0); #1;
    chk("busy_refuse", 64'(resp4), 64'd0);
    @(negedge clock); b4 = 1'b0; drv4(2'd3, 32'h1000, 64'hFFFF); #1;
    chk("cmd3_refuse", 64'(resp4), 64'd0);
    @(negedge clock); drv4(MEM_CMD_LOAD, 32'h1000, 64'h0); #1;
    chk("tag_unchanged", 64'(resp4), 64'd7);
    @(negedge clock); drv4(MEM_CMD_NONE, 32'h0, 64'h0);
    chk("c17_idle", 64'(rtag4), 64'd0);
    @(negedge clock);
    chk("busy_no_cpl", 64'(rtag4), 64'd0);
    @(negedge clock);
    chk("cmd3_no_cpl", 64'(rtag4), 64'd0);
    // cycle 20..23: out-of-range store/load
    @(negedge clock);
    chk("c20_tag", 64'(rtag4), 64'd7);
    chk("cmd3_no_write", rdata4, 64'h5555);
    drv4(MEM_CMD_STORE, 32'h0, 64'h77); #1;
    chk("c20_grant", 64'(resp4), 64'd8);
    @(negedge clock); drv4(MEM_CMD_STORE, 32'h0001_0000, 64'hAAAA); #1;
    chk("oob_store_grant", 64'(resp4), 64'd9);
    @(negedge clock); drv4(MEM_CMD_LOAD, 32'h0001_0000, 64'h0); #1;
    chk("oob_load_grant", 64'(resp4), 64'd10);
    @(negedge clock); drv4(MEM_CMD_LOAD, 32'h0, 64'h0); #1;
    chk("c23_grant", 64'(resp4), 64'd11);
    @(negedge clock); drv4(MEM_CMD_NONE, 32'h0, 64'h0);
    chk("c24_tag", 64'(rtag4), 64'd8);
    @(negedge clock);
    chk("oob_store_cpl", 64'(rtag4), 64'd9);
    chk("oob_store_data", rdata4, 64'h0);
    @(negedge clock);
    chk("oob_load_tag", 64'(rtag4), 64'd10);
    chk("oob_load_data", rdata4, 64'h0);
    @(negedge clock);
    chk("no_alias_tag", 64'(rtag4), 64'd11);
    chk("no_alias_data", rdata4, 64'h77);
    // cycle 28: load, cycle 30: reset
    @(negedge clock); drv4(MEM_CMD_LOAD, 32'h1000, 64'h0); #1;
    chk("c28_grant", 64'(resp4), 64'd12);
    @(negedge clock); drv4(MEM_CMD_NONE, 32'h0, 64'h0);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    for (int n = 31; n <= 38; n++) begin
      if (n > 31) @(negedge clock);
      chk("reset_drops", 64'(rtag4), 64'd0);
    end
    @(negedge clock); drv4(MEM_CMD_LOAD, 32'h1000, 64'h0); #1;
    chk("post_reset_tag1", 64'(resp4), 64'd1);
    @(negedge clock); drv4(MEM_CMD_NONE, 32'h0, 64'h0);
    repeat (2) @(negedge clock);
    @(negedge clock);
    chk("post_reset_cpl", 64'(rtag4), 64'd1);
    chk("store_survives", rdata4, 64'h5555);

    // LATENCY=20: load every cycle 0..21
    for (int n = 0; n < 22; n++) begin
      @(negedge clock);
      chk("l20_rtag", 64'(rtag20), (n == 20) ? 64'd1 : (n == 21) ? 64'd2 : 64'd0);
      if (n < 20) chk("l20_rdata_idle", rdata20, 64'h0);
      c20 = MEM_CMD_LOAD; a20 = 32'h2000; #1;
      chk("l20_resp", 64'(resp20), (n < 15) ? 64'(n + 1) : (n == 21) ? 64'd1 : 64'd0);
    end
    @(negedge clock); c20 = MEM_CMD_NONE;
    repeat (2) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
